// File: rtl/instr_encoder.sv
// Instruction encoder / program loader.
// Accepts field-level RV32I instructions (addi, lw, bne), assembles each into a 32-bit word and
// writes it little-endian, one byte per cycle, through a byte-wide instruction memory port.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready field handshake; in_op 0=addi 1=lw 2=bne 3=illegal
//   in_rd, in_rs1, in_rs2, in_imm  instruction fields (in_imm is 13-bit signed)
//   clear             restore write pointer to BASE_ADDR and clear err (idle only)
//   mem_we, mem_addr, mem_wdata    byte write port
//   instr_word        last encoded word
//   done              pulse with the last byte of a word
//   err               sticky error flag
//
// Optional feature macro: INSTR_ENCODER_IMM_CHECK_EN
//   When defined, out-of-range addi/lw immediates and odd bne offsets are rejected like an
//   illegal op. When undefined, immediates are silently truncated.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  input  logic                  clear,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [31:0]           instr_word,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] Base = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [1:0]            idx_q;

  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic [1:0]  idx_next;
  logic [31:0] word_shift;

  always_comb begin
    enc_word = '0;
    unique case (in_op)
      2'd0:    enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      2'd1:    enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      2'd2:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001, in_imm[4:1],
                           in_imm[11], 7'b1100011};
      default: enc_word = '0;
    endcase
  end

`ifdef INSTR_ENCODER_IMM_CHECK_EN
  always_comb begin
    legal = (in_op != 2'd3);
    if (in_op == 2'd0 || in_op == 2'd1) begin
      legal = (in_imm[12] == in_imm[11]);
    end else if (in_op == 2'd2) begin
      legal = !in_imm[0];
    end
  end
`else
  logic unused_imm0;
  assign unused_imm0 = in_imm[0];
  always_comb begin
    legal = (in_op != 2'd3);
  end
`endif

  // in_ready is registered high exactly in StIdle, so it doubles as the idle qualifier.
  assign accept     = in_valid && in_ready;
  assign idx_next   = idx_q + 2'd1;
  assign word_shift = instr_word >> {idx_next, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= Base;
      mem_wdata  <= '0;
      instr_word <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      ptr_q      <= Base;
      idx_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done   <= 1'b0;
          mem_we <= 1'b0;
          // Clear takes effect first so a same-cycle accept lands at Base with a fresh err.
          if (clear) begin
            ptr_q <= Base;
            err   <= 1'b0;
          end
          if (accept) begin
            if (legal) begin
              state_q    <= StWrite;
              in_ready   <= 1'b0;
              instr_word <= enc_word;
              idx_q      <= '0;
              mem_we     <= 1'b1;
              mem_addr   <= clear ? Base : ptr_q;
              mem_wdata  <= enc_word[7:0];
            end else begin
              err <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (idx_q == 2'd3) begin
            state_q  <= StIdle;
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            ptr_q    <= ptr_q + ADDR_WIDTH'(4);
          end else begin
            idx_q     <= idx_next;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= word_shift[7:0];
            done      <= (idx_next == 2'd3);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. Two instances share stimulus: A (12-bit address,
// base 0) and B (4-bit address, base 12, exercising wrap-around). A field-level reference model
// predicts the encoded word, legality, write addresses and the sticky error flag.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        clear = 1'b0;

  logic        rdy_w  [2];
  logic        we_w   [2];
  logic [7:0]  wd_w   [2];
  logic [31:0] iw_w   [2];
  logic        done_w [2];
  logic        err_w  [2];
  logic [11:0] addr_w [2];
  logic [11:0] addr_a;
  logic [3:0]  addr_b;

  int errors = 0;
  int checks = 0;

  int base_m [2] = '{0, 12};
  int size_m [2] = '{4096, 16};
  int ptr_m  [2];
  bit err_m;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(12), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .clear(clear),
    .mem_we(we_w[0]), .mem_addr(addr_a), .mem_wdata(wd_w[0]), .instr_word(iw_w[0]),
    .done(done_w[0]), .err(err_w[0])
  );

  instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .clear(clear),
    .mem_we(we_w[1]), .mem_addr(addr_b), .mem_wdata(wd_w[1]), .instr_word(iw_w[1]),
    .done(done_w[1]), .err(err_w[1])
  );

  assign addr_w[0] = addr_a;
  assign addr_w[1] = {8'b0, addr_b};

  // Reference encoder built from the instruction-format rules using integer arithmetic.
  function automatic logic [31:0] ref_encode(input logic [1:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [12:0] imm);
    int          s;
    int unsigned lo12, b, r1, r2, d;
    s    = imm[12] ? int'(imm) - 8192 : int'(imm);
    lo12 = s & 'hfff;
    b    = s & 'h1ffe;
    r1   = rs1;
    r2   = rs2;
    d    = rd;
    case (op)
      2'd0:    return (lo12 << 20) | (r1 << 15) | (d << 7) | 'h13;
      2'd1:    return (lo12 << 20) | (r1 << 15) | (2 << 12) | (d << 7) | 'h03;
      2'd2:    return (((b >> 12) & 1) << 31) | (((b >> 5) & 'h3f) << 25) | (r2 << 20) |
                      (r1 << 15) | (1 << 12) | (((b >> 1) & 'hf) << 8) |
                      (((b >> 11) & 1) << 7) | 'h63;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [1:0] op, input logic [12:0] imm);
    int s;
    s = imm[12] ? int'(imm) - 8192 : int'(imm);
    if (op == 2'd3) return 1'b0;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    if (op != 2'd2) return (s >= -2048 && s <= 2047);
    return (s % 2 == 0);
`else
    return (s == s);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) ptr_m[i] = base_m[i];
    err_m = 1'b0;
  endtask

  // Offers one instruction in idle and follows it cycle by cycle against the model.
  task automatic send_instr(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [12:0] imm, input bit clr);
    logic [31:0] exp;
    logic [11:0] ea;
    logic [7:0]  eb;
    bit          lg;
    exp = ref_encode(op, rd, rs1, rs2, imm);
    lg  = ref_legal(op, imm);
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1; clear = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clear = 1'b0;
    if (clr) begin
      for (int i = 0; i < 2; i++) ptr_m[i] = base_m[i];
      err_m = 1'b0;
    end
    if (!lg) err_m = 1'b1;
    if (lg) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 2; i++) begin
          ea = 12'((ptr_m[i] + k) % size_m[i]);
          eb = 8'(exp >> (8 * k));
          checks++;
          if (we_w[i] !== 1'b1 || addr_w[i] !== ea || wd_w[i] !== eb ||
              done_w[i] !== (k == 3) || rdy_w[i] !== 1'b0 || iw_w[i] !== exp ||
              err_w[i] !== err_m) begin
            errors++;
            $display("FAIL write dut%0d byte%0d: got we=%b addr=%h data=%h done=%b rdy=%b word=%h err=%b; want we=1 addr=%h data=%h done=%b rdy=0 word=%h err=%b",
                     i, k, we_w[i], addr_w[i], wd_w[i], done_w[i], rdy_w[i], iw_w[i],
                     err_w[i], ea, eb, (k == 3), exp, err_m);
          end
        end
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 2; i++) ptr_m[i] = (ptr_m[i] + 4) % size_m[i];
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (we_w[i] !== 1'b0 || rdy_w[i] !== 1'b1 || done_w[i] !== 1'b0 || err_w[i] !== err_m ||
          (lg && iw_w[i] !== exp)) begin
        errors++;
        $display("FAIL idle dut%0d op=%0d: got we=%b rdy=%b done=%b err=%b word=%h; want we=0 rdy=1 done=0 err=%b word=%h",
                 i, op, we_w[i], rdy_w[i], done_w[i], err_w[i], iw_w[i], err_m, exp);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy_w[i] !== 1'b1 || we_w[i] !== 1'b0 || addr_w[i] !== 12'(base_m[i]) ||
          wd_w[i] !== 8'h00 || iw_w[i] !== 32'h0 || done_w[i] !== 1'b0 || err_w[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d: got rdy=%b we=%b addr=%h data=%h word=%h done=%b err=%b; want 1 0 %h 00 0 0 0",
                 tag, i, rdy_w[i], we_w[i], addr_w[i], wd_w[i], iw_w[i], done_w[i], err_w[i],
                 12'(base_m[i]));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    send_instr(2'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    checks++;
    if (iw_w[0] !== 32'h00500093) begin
      errors++;
      $display("FAIL addi_word: got %h want 00500093", iw_w[0]);
    end
    // Second word wraps to address 0 on the 4-bit instance.
    send_instr(2'd0, 5'd3, 5'd2, 5'd0, 13'h1FFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2];
    logic [11:0] ea;
    logic [7:0]  eb;
    logic [31:0] ew;
    int          j, k;
    bit          ewe, erdy, edone;
    w[0] = 32'h0040A103;
    w[1] = 32'hFE009EE3;
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_rd = 5'd2; in_rs1 = 5'd1; in_rs2 = 5'd0; in_imm = 13'd4;
    @(posedge clk);
    #1;
    in_op = 2'd2; in_rd = 5'd0; in_rs1 = 5'd1; in_rs2 = 5'd0; in_imm = 13'h1FFC;
    for (int c = 1; c <= 9; c++) begin
      j     = (c <= 5) ? 0 : 1;
      k     = (c <= 5) ? c - 1 : c - 6;
      ewe   = (c != 5);
      erdy  = (c == 5);
      edone = (c == 4 || c == 9);
      ew    = w[j];
      for (int i = 0; i < 2; i++) begin
        ea = 12'((ptr_m[i] + 4 * j + k) % size_m[i]);
        eb = 8'(ew >> (8 * k));
        checks++;
        if (we_w[i] !== ewe || rdy_w[i] !== erdy || done_w[i] !== edone || iw_w[i] !== ew ||
            (ewe && (addr_w[i] !== ea || wd_w[i] !== eb))) begin
          errors++;
          $display("FAIL b2b dut%0d cycle%0d: got we=%b rdy=%b done=%b word=%h addr=%h data=%h; want we=%b rdy=%b done=%b word=%h addr=%h data=%h",
                   i, c, we_w[i], rdy_w[i], done_w[i], iw_w[i], addr_w[i], wd_w[i],
                   ewe, erdy, edone, ew, ea, eb);
        end
      end
      if (c == 6) in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) ptr_m[i] = (ptr_m[i] + 8) % size_m[i];
  endtask

  task automatic test_illegal_clear();
    send_instr(2'd3, 5'd4, 5'd5, 5'd6, 13'd7, 1'b0);
    checks++;
    if (err_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err: got %b want 1", err_w[0]);
    end
    // Legal word at the unchanged pointer; err stays set.
    send_instr(2'd0, 5'd7, 5'd8, 5'd0, 13'd100, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    checks++;
    if (err_w[0] !== 1'b0 || err_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: got %b/%b want 0/0", err_w[0], err_w[1]);
    end
    send_instr(2'd1, 5'd9, 5'd10, 5'd0, 13'd8, 1'b0);
    send_instr(2'd3, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
    // Clear together with a legal accept: word goes to base, err reflects only the new op.
    send_instr(2'd2, 5'd0, 5'd3, 5'd4, 13'd16, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    in_op = 2'd0; in_rd = 5'd5; in_rs1 = 5'd6; in_imm = 13'd33; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_write");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_instr(2'd0, 5'd1, 5'd2, 5'd0, 13'd12, 1'b0);
  endtask

  task automatic test_imm();
    send_instr(2'd0, 5'd1, 5'd0, 5'd0, 13'd2048, 1'b0);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    checks++;
    if (err_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL imm_range_err: got %b want 1", err_w[0]);
    end
`else
    checks++;
    if (iw_w[0] !== 32'h80000093 || err_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL imm_trunc: got word=%h err=%b want 80000093 0", iw_w[0], err_w[0]);
    end
`endif
    send_instr(2'd2, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      send_instr(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                 13'($urandom), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal_clear();
    test_reset_mid_write();
    test_imm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction decode path: accepts field-level instructions (op, rd, rs1, rs2, imm) and assembles them into 32-bit RV32I words.
- Supported ops are addi, lw and bne; encodings match the opcode and immediate-format constants in types_pkg.
- Each assembled word is written little-endian, one byte per cycle, into the byte-wide write port of instruction memory.
- Used as the program loader in front of instruction memory in testbenches and at bring-up.

Parameters:
- ADDR_WIDTH, 12, width of instruction memory byte address.
- BASE_ADDR, 0, byte address of the first written instruction; also the address restored by clear.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction fields valid.
- in_ready  output  1  encoder can accept fields.
- in_op  input  2  0=addi, 1=lw, 2=bne, 3=illegal.
- in_rd  input  5  destination register (addi, lw).
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2 (bne).
- in_imm  input  13  signed immediate or byte offset.
- clear  input  1  restore address to BASE_ADDR and clear err; honoured only in IDLE.
- mem_we  output  1  byte write strobe.
- mem_addr  output  ADDR_WIDTH  byte address.
- mem_wdata  output  8  byte data.
- instr_word  output  32  last encoded word.
- done  output  1  one-cycle pulse on the last byte of a word.
- err  output  1  sticky error flag.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, in_ready=1.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - instr_word=0, done=0, err=0.
  - Internal write pointer=BASE_ADDR, byte index=0.
- Encoding:
  - addi: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - lw: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - bne: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
  - Unused fields (rs2 for I-type; rd for bne) are ignored.
- FSM states: IDLE and WRITE.
- IDLE:
  - in_ready=1.
  - An accept is in_valid && in_ready at a rising edge. On a legal accept: instr_word <= encoded word, byte index <= 0, go to WRITE.
  - On an illegal accept (op=3): fields are consumed and dropped, err <= 1, no memory write, stay in IDLE.
  - clear=1 with no accept: pointer <= BASE_ADDR, err <= 0.
  - clear together with an accept: clear is applied first, so the accepted word is written at BASE_ADDR; err reflects only the new instruction.
- WRITE:
  - in_ready=0, mem_we=1 for exactly 4 consecutive cycles.
  - Byte k: mem_addr = pointer + k, mem_wdata = instr_word[8k+7:8k].
  - done=1 in the cycle of byte 3. The next cycle is IDLE with pointer += 4.
  - clear is ignored in WRITE.
- Latency: accept at edge N; bytes are driven in cycles N+1..N+4; in_ready returns in cycle N+5. Throughput is one word per 5 cycles.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent and raises no error.
- Reset mid-WRITE aborts the word immediately; partial bytes stay in memory; all state returns to reset values.
- All outputs are registered; mem_we, mem_addr and mem_wdata change only on clock edges.

Optional Feature:
- Macro: INSTR_ENCODER_IMM_CHECK_EN.
- Defined:
  - addi and lw require in_imm[12]==in_imm[11], i.e. the value fits in 12-bit signed.
  - bne requires in_imm[0]==0.
  - A violation is handled like an illegal op: dropped, err <= 1, no write.
- Undefined:
  - addi and lw silently truncate to imm[11:0].
  - bne silently ignores imm[0].
  - err is set only by op=3.

Test Plan:
- Reset then addi rd=1, rs1=0, imm=5 at BASE_ADDR=0 -> instr_word=0x00500093; bytes 93,00,50,00 at addresses 0..3; done in the 4th write cycle; in_ready low for 4 cycles.
- Back-to-back in_valid held high with lw rd=2, rs1=1, imm=4 then bne rs1=1, rs2=0, imm=-4 -> 0x0040A103 at addresses 0..3, then 0xFE009EE3 at addresses 4..7; second accept occurs exactly 5 cycles after the first.
- in_op=3 in IDLE -> no mem_we, err=1 and held; subsequent addi still writes at the unchanged pointer; clear -> err=0, pointer=0.
- ADDR_WIDTH=4, BASE_ADDR=12, two addi words -> second word written at addresses 0..3 (wrap), err stays 0.
- rst_n low after byte 1 of a word -> outputs at reset values immediately, no done; next word written at BASE_ADDR.
- With INSTR_ENCODER_IMM_CHECK_EN: addi imm=2048 or bne imm=3 -> dropped, err=1. Without it: addi imm=2048 -> 0x80000093 written (truncated to -2048), err=0.
